// File: rtl/kbd_event_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_event_queue_if
//  Description : Event stream between the keyboard event queue (master) and
//                its consumer (slave): head event, valid and ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kbd_event_queue_if;
  logic [9:0] ev_data;   // {extend, break, code[7:0]}
  logic       ev_valid;
  logic       ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/kbd_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_event_queue
//  Description : PS/2 scan-code decoder. Resolves E0/F0 prefixes into
//                make/break events for 512 key indices, keeps a key-down
//                bitmap and queues every event in a show-ahead FIFO.
//                Optional macro KBD_REPEAT_FILTER_EN suppresses typematic
//                repeats (makes of keys already held) from the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_event_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 100000
) (
  input  wire                         clk,
  input  wire                         rst,
  input  wire  [7:0]                  rx_data,
  input  wire                         rx_valid,
  kbd_event_queue_if.master           ev_if,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [511:0]                key_down,
  output logic [8:0]                  last_change,
  output logic                        evt_strobe,
  output logic                        overflow,
  input  wire                         clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_PREFIX = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [511:0]    key_down_q, key_down_d;
  logic [8:0]      last_change_q, last_change_d;
  logic            evt_strobe_q, evt_strobe_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      mem_q [DEPTH];

  logic            push_req;
  logic [9:0]      push_data;
  logic            push_ok;
  logic            pop;
  logic            fifo_nonempty;
  logic [8:0]      idx;
  logic            is_ignored;

  assign idx        = {ext_q, rx_data};
  // Link-level housekeeping bytes only matter when no prefix is pending;
  // after a prefix they are ordinary scan codes.
  assign is_ignored = (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                      (rx_data == 8'h00) || (rx_data == 8'hFF);

  // Parser: prefix tracking, prefix timeout, key bitmap and event generation
  always_comb begin
    state_d       = state_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    tmo_d         = tmo_q;
    key_down_d    = key_down_q;
    last_change_d = last_change_q;
    push_req      = 1'b0;
    push_data     = {ext_q, brk_q, rx_data};
    if (rx_valid) begin
      if (rx_data == 8'hE0) begin
        ext_d   = 1'b1;
        state_d = S_PREFIX;
        tmo_d   = '0;
      end else if (rx_data == 8'hF0) begin
        brk_d   = 1'b1;
        state_d = S_PREFIX;
        tmo_d   = '0;
      end else if ((state_q == S_IDLE) && (rx_data == 8'hAA)) begin
        // Keyboard self-test finished: nothing can be held any more.
        key_down_d = '0;
      end else if (!((state_q == S_IDLE) && is_ignored)) begin
        last_change_d   = idx;
        key_down_d[idx] = ~brk_q;
`ifdef KBD_REPEAT_FILTER_EN
        // A make of a key already held is typematic repeat; breaks always go.
        push_req = brk_q | ~key_down_q[idx];
`else
        push_req = 1'b1;
`endif
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = S_IDLE;
        tmo_d   = '0;
      end
    end else if (state_q == S_PREFIX) begin
      if (tmo_q == TMO_LAST) begin
        // Orphaned prefix: drop it silently.
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // FIFO bookkeeping: a pop in the same cycle frees room for a push
  always_comb begin
    fifo_nonempty = (count_q != '0);
    pop           = fifo_nonempty & ev_if.ev_ready;
    push_ok       = push_req & ((count_q != FULL_CNT) | pop);
    wr_ptr_d      = wr_ptr_q + AW'(push_ok);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new drop wins over a simultaneous clear.
    if (push_req & ~push_ok)
      overflow_d = 1'b1;
    else if (clear_ovf)
      overflow_d = 1'b0;
    else
      overflow_d = overflow_q;
    evt_strobe_d = push_req;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      tmo_q         <= '0;
      key_down_q    <= '0;
      last_change_q <= '0;
      evt_strobe_q  <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      tmo_q         <= tmo_d;
      key_down_q    <= key_down_d;
      last_change_q <= last_change_d;
      evt_strobe_q  <= evt_strobe_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Event storage; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= push_data;
  end

  assign ev_if.ev_valid = fifo_nonempty;
  assign ev_if.ev_data  = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
  assign count          = count_q;
  assign key_down       = key_down_q;
  assign last_change    = last_change_q;
  assign evt_strobe     = evt_strobe_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kbd_event_queue
//  Description : Self-checking bench for kbd_event_queue: directed scenarios
//                plus random byte streams against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_event_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           clear_ovf = 1'b0;
  logic [CW-1:0]  count;
  logic [511:0]   key_down;
  logic [8:0]     last_change;
  logic           evt_strobe;
  logic           overflow;

  kbd_event_queue_if ev_if();

  kbd_event_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ev_if      (ev_if.master),
    .count      (count),
    .key_down   (key_down),
    .last_change(last_change),
    .evt_strobe (evt_strobe),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending prefix flags, queue of events, key set.
  logic [9:0]   mq[$];
  logic [511:0] mkeys;
  logic [8:0]   m_last;
  logic         m_ovf, m_strobe, m_ext, m_brk;
  int           m_idle;

  function automatic logic [9:0] m_head();
    return (mq.size() != 0) ? mq[0] : 10'h000;
  endfunction

  task automatic model_reset();
    mq.delete();
    mkeys = '0; m_last = '0; m_ovf = 0; m_strobe = 0;
    m_ext = 0; m_brk = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic v,
                            input logic rdy, input logic clr);
    bit push, pop;
    logic [8:0] k;
    logic [9:0] ev;
    push = 0;
    ev = '0;
    pop = (mq.size() != 0) && rdy;
    if (v) begin
      if (d == 8'hE0) begin
        m_ext = 1; m_idle = 0;
      end else if (d == 8'hF0) begin
        m_brk = 1; m_idle = 0;
      end else if (!m_ext && !m_brk && d == 8'hAA) begin
        mkeys = '0;
      end else if (!m_ext && !m_brk &&
                   (d == 8'hFA || d == 8'hFE || d == 8'h00 || d == 8'hFF)) begin
        push = 0;
      end else begin
        k = {m_ext, d};
        m_last = k;
        push = 1;
`ifdef KBD_REPEAT_FILTER_EN
        if (!m_brk && mkeys[k]) push = 0;
`endif
        mkeys[k] = !m_brk;
        ev = {m_ext, m_brk, d};
        m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle >= TIMEOUT) begin
        m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end
    if (clr) m_ovf = 0;
    if (pop) void'(mq.pop_front());
    m_strobe = push;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  // Drive one cycle of inputs (called at a negedge) and step the model.
  task automatic tick(input logic [7:0] d, input logic v,
                      input logic rdy, input logic clr);
    rx_data = d; rx_valid = v; ev_if.ev_ready = rdy; clear_ovf = clr;
    model_step(d, v, rdy, clr);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() != 0 && n < 64) begin
      tick(8'h00, 1'b0, 1'b1, 1'b0);
      n++;
    end
    tick(8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if (ev_if.ev_valid !== 1'b0 || count !== '0) begin
      bad++;
      $display("FAIL drain: ev_valid=%b count=%0d, required 0/0", ev_if.ev_valid, count);
    end
  endtask

  task automatic test_reset();
    ev_if.ev_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (ev_if.ev_valid !== 0 || ev_if.ev_data !== 10'h000 || count !== '0 ||
        key_down !== '0 || last_change !== 9'h000 || evt_strobe !== 0 || overflow !== 0) begin
      bad++;
      $display("FAIL reset_values: valid=%b data=%h count=%0d last=%h strobe=%b ovf=%b, required all 0",
               ev_if.ev_valid, ev_if.ev_data, count, last_change, evt_strobe, overflow);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if (count !== '0 || ev_if.ev_valid !== 0) begin
      bad++;
      $display("FAIL reset_release: count=%0d valid=%b, required 0/0", count, ev_if.ev_valid);
    end
  endtask

  task automatic test_make_break();
    tick(8'h1C, 1, 1, 0);
    total++;
    if (key_down[9'h01C] !== 1 || ev_if.ev_valid !== 1 || ev_if.ev_data !== 10'h01C || evt_strobe !== 1) begin
      bad++;
      $display("FAIL make_1c: key=%b valid=%b data=%h strobe=%b, required 1/1/01c/1",
               key_down[9'h01C], ev_if.ev_valid, ev_if.ev_data, evt_strobe);
    end
    tick(8'hF0, 1, 1, 0);
    tick(8'h1C, 1, 1, 0);
    total++;
    if (key_down[9'h01C] !== 0 || ev_if.ev_data !== 10'h11C || last_change !== 9'h01C || count !== CW'(1)) begin
      bad++;
      $display("FAIL break_1c: key=%b data=%h last=%h count=%0d, required 0/11c/01c/1",
               key_down[9'h01C], ev_if.ev_data, last_change, count);
    end
    drain();
  endtask

  task automatic test_extended();
    tick(8'hE0, 1, 0, 0);
    tick(8'h75, 1, 0, 0);
    total++;
    if (key_down[9'h175] !== 1 || ev_if.ev_data !== 10'h275 || count !== CW'(1)) begin
      bad++;
      $display("FAIL ext_make: key=%b data=%h count=%0d, required 1/275/1",
               key_down[9'h175], ev_if.ev_data, count);
    end
    tick(8'hE0, 1, 0, 0);
    tick(8'hF0, 1, 0, 0);
    tick(8'h75, 1, 0, 0);
    total++;
    if (key_down[9'h175] !== 0 || last_change !== 9'h175 || count !== CW'(2)) begin
      bad++;
      $display("FAIL ext_break: key=%b last=%h count=%0d, required 0/175/2",
               key_down[9'h175], last_change, count);
    end
    tick(8'h00, 0, 1, 0);
    total++;
    if (ev_if.ev_data !== 10'h375 || count !== CW'(1)) begin
      bad++;
      $display("FAIL ext_order: data=%h count=%0d, required 375/1", ev_if.ev_data, count);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] code;
    for (int i = 0; i <= DEPTH; i++) begin
      code = 8'h10 + 8'(i);
      tick(code, 1, 0, 0);
    end
    total++;
    if (count !== CW'(DEPTH) || overflow !== 1 || key_down[{1'b0, code}] !== 1 ||
        ev_if.ev_data !== 10'h010 || evt_strobe !== 1) begin
      bad++;
      $display("FAIL overflow_fill: count=%0d ovf=%b key=%b head=%h strobe=%b, required %0d/1/1/010/1",
               count, overflow, key_down[{1'b0, code}], ev_if.ev_data, evt_strobe, DEPTH);
    end
    tick(8'h15, 1, 0, 1);
    total++;
    if (overflow !== 1 || count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL overflow_set_wins: ovf=%b count=%0d, required 1/%0d", overflow, count, DEPTH);
    end
    tick(8'h00, 0, 1, 1);
    total++;
    if (overflow !== 0 || count !== CW'(DEPTH - 1) || ev_if.ev_data !== 10'h011) begin
      bad++;
      $display("FAIL overflow_clear_pop: ovf=%b count=%0d head=%h, required 0/%0d/011",
               overflow, count, ev_if.ev_data, DEPTH - 1);
    end
    drain();
  endtask

  task automatic test_timeout();
    tick(8'hE0, 1, 0, 0);
    repeat (TIMEOUT) tick(8'h00, 0, 0, 0);
    tick(8'h1C, 1, 0, 0);
    total++;
    if (ev_if.ev_data !== 10'h01C || key_down[9'h01C] !== 1 || key_down[9'h11C] !== 0) begin
      bad++;
      $display("FAIL timeout_expired: head=%h key01c=%b key11c=%b, required 01c/1/0",
               ev_if.ev_data, key_down[9'h01C], key_down[9'h11C]);
    end
    drain();
    tick(8'hE0, 1, 0, 0);
    repeat (TIMEOUT / 2) tick(8'h00, 0, 0, 0);
    tick(8'h1C, 1, 0, 0);
    total++;
    if (ev_if.ev_data !== 10'h21C || key_down[9'h11C] !== 1) begin
      bad++;
      $display("FAIL timeout_alive: head=%h key11c=%b, required 21c/1", ev_if.ev_data, key_down[9'h11C]);
    end
    tick(8'hF0, 1, 1, 0);
    tick(8'h1C, 1, 1, 0);
    tick(8'hE0, 1, 1, 0);
    tick(8'hF0, 1, 1, 0);
    tick(8'h1C, 1, 1, 0);
    drain();
  endtask

  task automatic test_repeat();
    int strobes = 0;
    int expected;
`ifdef KBD_REPEAT_FILTER_EN
    expected = 2;
`else
    expected = 4;
`endif
    tick(8'h1C, 1, 0, 0); strobes += int'(evt_strobe);
    tick(8'h1C, 1, 0, 0); strobes += int'(evt_strobe);
    tick(8'h1C, 1, 0, 0); strobes += int'(evt_strobe);
    tick(8'hF0, 1, 0, 0); strobes += int'(evt_strobe);
    tick(8'h1C, 1, 0, 0); strobes += int'(evt_strobe);
    total++;
    if (int'(count) !== expected || strobes !== expected || last_change !== 9'h01C) begin
      bad++;
      $display("FAIL repeat_filter: count=%0d strobes=%0d last=%h, required %0d/%0d/01c",
               count, strobes, last_change, expected, expected);
    end
    drain();
  endtask

  task automatic test_bat();
    tick(8'h1C, 1, 0, 0);
    tick(8'h23, 1, 0, 0);
    tick(8'hAA, 1, 0, 0);
    total++;
    if (key_down !== '0 || count !== CW'(2) || evt_strobe !== 0) begin
      bad++;
      $display("FAIL bat_clear: keys_zero=%b count=%0d strobe=%b, required 1/2/0",
               key_down == '0, count, evt_strobe);
    end
    drain();
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 13))
      0, 1:    return 8'hE0;
      2, 3:    return 8'hF0;
      4:       return 8'hAA;
      5:       return 8'hFA;
      6:       return 8'h00;
      7:       return 8'h1C;
      8:       return 8'h23;
      9:       return 8'h75;
      10:      return 8'h5A;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0)
        repeat ($urandom_range(1, TIMEOUT + 4)) tick(8'h00, 0, $urandom_range(0, 1) == 0, 0);
      else
        tick(pick_byte(), $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
             $urandom_range(0, 19) == 0);
      total++;
      if (ev_if.ev_valid !== (mq.size() != 0) || ev_if.ev_data !== m_head() ||
          count !== CW'(mq.size()) || key_down !== mkeys || last_change !== m_last ||
          evt_strobe !== m_strobe || overflow !== m_ovf) begin
        bad++;
        $display("FAIL random[%0d]: data=%h cnt=%0d last=%h strb=%b ovf=%b keys_ok=%b, required data=%h cnt=%0d last=%h strb=%b ovf=%b",
                 i, ev_if.ev_data, count, last_change, evt_strobe, overflow, key_down === mkeys,
                 m_head(), mq.size(), m_last, m_strobe, m_ovf);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    tick(8'h1C, 1, 0, 0);
    tick(8'h23, 1, 0, 0);
    tick(8'hE0, 1, 0, 0);
    #2 rst = 1;
    #1;
    total++;
    if (count !== '0 || ev_if.ev_valid !== 0 || key_down !== '0 || last_change !== 9'h000) begin
      bad++;
      $display("FAIL reset_async: count=%0d valid=%b keys_zero=%b last=%h, required 0/0/1/000",
               count, ev_if.ev_valid, key_down == '0, last_change);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    tick(8'h1C, 1, 0, 0);
    total++;
    if (ev_if.ev_data !== 10'h01C || count !== CW'(1)) begin
      bad++;
      $display("FAIL reset_prefix_lost: head=%h count=%0d, required 01c/1", ev_if.ev_data, count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ev_if.ev_ready = 0;
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_timeout();
    test_repeat();
    test_bat();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
